// File: rtl/sync_fifo_flow.sv
// Synchronous FIFO with protected push/pop, arbitrary depth, occupancy count,
// flush and selectable FWFT/registered read. Sticky error flags: SYNC_FIFO_ERR_EN.
module sync_fifo_flow #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 1,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             a_full,
  output logic             a_empty,
  output logic [CNT_W-1:0] count
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_TH   = CNT_W'(DEPTH - AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_TH   = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_flow: DEPTH must be >= 2");
    end
    if (AF_LEVEL < 0 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
      $error("sync_fifo_flow: AF_LEVEL must be in 0..DEPTH-1");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_flow: AE_LEVEL must be in 0..DEPTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [PTR_W-1:0] w_wr_nxt;
  logic [PTR_W-1:0] w_rd_nxt;

  assign full    = (r_count == DEPTH_C);
  assign empty   = (r_count == '0);
  assign a_full  = (r_count >= AF_TH);
  assign a_empty = (r_count <= AE_TH);
  assign count   = r_count;

  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Explicit wrap so non-power-of-two depths work.
  assign w_wr_nxt = (r_wr_ptr == LAST_P) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt = (r_rd_ptr == LAST_P) ? '0 : r_rd_ptr + 1'b1;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= w_wr_nxt;
      if (w_pop_ok)  r_rd_ptr <= w_rd_nxt;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout       = r_mem[r_rd_ptr];
      assign dout_valid = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] r_dout;
      logic             r_dout_valid;
      // Flush clears the valid strobe but leaves the last word on dout.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout       <= '0;
          r_dout_valid <= 1'b0;
        end else if (flush) begin
          r_dout_valid <= 1'b0;
        end else begin
          r_dout_valid <= w_pop_ok;
          if (w_pop_ok) r_dout <= r_mem[r_rd_ptr];
        end
      end
      assign dout       = r_dout;
      assign dout_valid = r_dout_valid;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!flush) begin
      if (push && full) r_overflow  <= 1'b1;
      if (pop && empty) r_underflow <= 1'b1;
    end
  end
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_flow.sv
// Bench for sync_fifo_flow: three instances (D16 FWFT, D5 FWFT, D16 registered)
// checked every cycle against a queue model plus directed literal expectations.
module tb_sync_fifo_flow;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        i_flush [NI];
  logic        i_push  [NI];
  logic        i_pop   [NI];
  logic [31:0] i_din   [NI];
  logic [31:0] o_dout  [NI];
  logic        o_dv    [NI];
  logic        o_full  [NI];
  logic        o_empty [NI];
  logic        o_af    [NI];
  logic        o_ae    [NI];
  logic [4:0]  cnt0;
  logic [2:0]  cnt1;
  logic [4:0]  cnt2;
  logic [31:0] o_cnt   [NI];
`ifdef SYNC_FIFO_ERR_EN
  logic        o_ovf   [NI];
  logic        o_unf   [NI];
`endif

  always #5 clk = ~clk;

  sync_fifo_flow #(.WIDTH(32), .DEPTH(16), .AF_LEVEL(2), .AE_LEVEL(2), .FWFT(1)) u_d16 (
    .clk(clk), .rst(rst), .flush(i_flush[0]), .push(i_push[0]), .din(i_din[0]),
    .pop(i_pop[0]), .dout(o_dout[0]), .dout_valid(o_dv[0]), .full(o_full[0]),
    .empty(o_empty[0]), .a_full(o_af[0]), .a_empty(o_ae[0]), .count(cnt0)
`ifdef SYNC_FIFO_ERR_EN
    , .overflow(o_ovf[0]), .underflow(o_unf[0])
`endif
  );

  sync_fifo_flow #(.WIDTH(32), .DEPTH(5), .AF_LEVEL(2), .AE_LEVEL(2), .FWFT(1)) u_d5 (
    .clk(clk), .rst(rst), .flush(i_flush[1]), .push(i_push[1]), .din(i_din[1]),
    .pop(i_pop[1]), .dout(o_dout[1]), .dout_valid(o_dv[1]), .full(o_full[1]),
    .empty(o_empty[1]), .a_full(o_af[1]), .a_empty(o_ae[1]), .count(cnt1)
`ifdef SYNC_FIFO_ERR_EN
    , .overflow(o_ovf[1]), .underflow(o_unf[1])
`endif
  );

  sync_fifo_flow #(.WIDTH(32), .DEPTH(16), .AF_LEVEL(2), .AE_LEVEL(2), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .flush(i_flush[2]), .push(i_push[2]), .din(i_din[2]),
    .pop(i_pop[2]), .dout(o_dout[2]), .dout_valid(o_dv[2]), .full(o_full[2]),
    .empty(o_empty[2]), .a_full(o_af[2]), .a_empty(o_ae[2]), .count(cnt2)
`ifdef SYNC_FIFO_ERR_EN
    , .overflow(o_ovf[2]), .underflow(o_unf[2])
`endif
  );

  always_comb begin
    o_cnt[0] = 32'(cnt0);
    o_cnt[1] = 32'(cnt1);
    o_cnt[2] = 32'(cnt2);
  end

  function automatic int dep(input int k);
    return (k == 1) ? 5 : 16;
  endfunction

  function automatic bit is_fwft(input int k);
    return (k != 2);
  endfunction

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q [NI][$];
  logic [31:0] m_dout [NI];
  logic        m_dv   [NI];
  logic        m_ovf  [NI];
  logic        m_unf  [NI];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  started  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      int sz;
      sz = exp_q[k].size();
      if (rst) begin
        exp_q[k].delete();
        m_dout[k] = '0;
        m_dv[k]   = 1'b0;
        m_ovf[k]  = 1'b0;
        m_unf[k]  = 1'b0;
      end else if (i_flush[k]) begin
        exp_q[k].delete();
        m_dv[k] = 1'b0;
      end else begin
        if (i_push[k] && sz == dep(k)) m_ovf[k] = 1'b1;
        if (i_pop[k] && sz == 0)       m_unf[k] = 1'b1;
        m_dv[k] = i_pop[k] && sz > 0;
        if (i_pop[k] && sz > 0) m_dout[k] = exp_q[k].pop_front();
        if (i_push[k] && sz < dep(k)) exp_q[k].push_back(i_din[k]);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < NI; k++) begin
        int sz;
        sz = exp_q[k].size();
        chk($sformatf("u%0d count", k), o_cnt[k], 32'(sz));
        chk($sformatf("u%0d full", k), 32'(o_full[k]), 32'(sz == dep(k)));
        chk($sformatf("u%0d empty", k), 32'(o_empty[k]), 32'(sz == 0));
        chk($sformatf("u%0d a_full", k), 32'(o_af[k]), 32'(sz >= dep(k) - 2));
        chk($sformatf("u%0d a_empty", k), 32'(o_ae[k]), 32'(sz <= 2));
        if (is_fwft(k)) begin
          chk($sformatf("u%0d dout_valid", k), 32'(o_dv[k]), 32'(sz > 0));
          if (sz > 0) chk($sformatf("u%0d dout", k), o_dout[k], exp_q[k][0]);
        end else begin
          chk($sformatf("u%0d dout_valid", k), 32'(o_dv[k]), 32'(m_dv[k]));
          chk($sformatf("u%0d dout", k), o_dout[k], m_dout[k]);
        end
`ifdef SYNC_FIFO_ERR_EN
        chk($sformatf("u%0d overflow", k), 32'(o_ovf[k]), 32'(m_ovf[k]));
        chk($sformatf("u%0d underflow", k), 32'(o_unf[k]), 32'(m_unf[k]));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int k, input bit p, input logic [31:0] d, input bit po, input bit fl);
    i_push[k]  = p;
    i_din[k]   = d;
    i_pop[k]   = po;
    i_flush[k] = fl;
    @(posedge clk);
    @(negedge clk);
    i_push[k]  = 1'b0;
    i_pop[k]   = 1'b0;
    i_flush[k] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < NI; k++) begin
      i_flush[k] = 1'b0;
      i_push[k]  = 1'b0;
      i_pop[k]   = 1'b0;
      i_din[k]   = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    started = 1'b1;
    chk("rst count", o_cnt[0], 32'd0);
    chk("rst empty", 32'(o_empty[0]), 32'd1);
    chk("rst a_empty", 32'(o_ae[0]), 32'd1);
    chk("rst full", 32'(o_full[0]), 32'd0);
    chk("rst a_full", 32'(o_af[0]), 32'd0);
    chk("rst reg dout", o_dout[2], 32'd0);
    chk("rst reg dout_valid", 32'(o_dv[2]), 32'd0);
    rst = 1'b0;

    // Fill 0x1..0x10, then drain.
    for (int i = 1; i <= 16; i++) begin
      step(0, 1'b1, 32'(i), 1'b0, 1'b0);
      chk("fill a_full", 32'(o_af[0]), 32'(i >= 14));
      chk("fill full", 32'(o_full[0]), 32'(i == 16));
    end
    step(0, 1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("push at full count", o_cnt[0], 32'd16);
`ifdef SYNC_FIFO_ERR_EN
    chk("overflow set", 32'(o_ovf[0]), 32'd1);
`endif
    for (int i = 1; i <= 16; i++) begin
      chk("drain dout", o_dout[0], 32'(i));
      step(0, 1'b0, 32'd0, 1'b1, 1'b0);
    end
    chk("drain empty", 32'(o_empty[0]), 32'd1);
    step(0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("pop at empty count", o_cnt[0], 32'd0);
`ifdef SYNC_FIFO_ERR_EN
    chk("underflow set", 32'(o_unf[0]), 32'd1);
    step(0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("overflow after flush", 32'(o_ovf[0]), 32'd1);
    chk("underflow after flush", 32'(o_unf[0]), 32'd1);
    pulse_reset();
    chk("overflow after rst", 32'(o_ovf[0]), 32'd0);
    chk("underflow after rst", 32'(o_unf[0]), 32'd0);
`endif

    // Simultaneous push+pop at count 3.
    for (int i = 0; i < 3; i++) step(0, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    chk("simul head", o_dout[0], 32'h100);
    step(0, 1'b1, 32'h200, 1'b1, 1'b0);
    chk("simul count", o_cnt[0], 32'd3);
    chk("simul dout 1", o_dout[0], 32'h101);
    step(0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("simul dout 2", o_dout[0], 32'h102);
    step(0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("simul dout 3", o_dout[0], 32'h200);
    step(0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Flush with concurrent push at count 7.
    for (int i = 0; i < 7; i++) step(0, 1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    chk("pre-flush count", o_cnt[0], 32'd7);
    step(0, 1'b1, 32'h77, 1'b0, 1'b1);
    chk("flush count", o_cnt[0], 32'd0);
    chk("flush empty", 32'(o_empty[0]), 32'd1);
    chk("flush dout_valid", 32'(o_dv[0]), 32'd0);
    step(0, 1'b1, 32'h55, 1'b0, 1'b0);
    chk("post-flush first", o_dout[0], 32'h55);
    step(0, 1'b0, 32'd0, 1'b1, 1'b0);

    // DEPTH=5 wrap: three rounds of push 5 / pop 5.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(1, 1'b1, 32'(r * 16 + i + 1), 1'b0, 1'b0);
      chk("d5 peak count", o_cnt[1], 32'd5);
      chk("d5 full", 32'(o_full[1]), 32'd1);
      for (int i = 0; i < 5; i++) begin
        chk("d5 order", o_dout[1], 32'(r * 16 + i + 1));
        step(1, 1'b0, 32'd0, 1'b1, 1'b0);
      end
      chk("d5 drained", o_cnt[1], 32'd0);
    end

    // Registered-read latency.
    step(2, 1'b1, 32'hA5, 1'b0, 1'b0);
    chk("reg no early valid", 32'(o_dv[2]), 32'd0);
    step(2, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("reg dout", o_dout[2], 32'hA5);
    chk("reg dout_valid", 32'(o_dv[2]), 32'd1);
    step(2, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("reg hold dout", o_dout[2], 32'hA5);
    chk("reg valid drop", 32'(o_dv[2]), 32'd0);

    // Registered-read sustained throughput: push+pop every cycle.
    step(2, 1'b1, 32'h10, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(2, 1'b1, 32'h10 + 32'(i), 1'b1, 1'b0);
      chk("reg stream dout", o_dout[2], 32'h10 + 32'(i - 1));
      chk("reg stream valid", 32'(o_dv[2]), 32'd1);
    end
    step(2, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("reg stream last", o_dout[2], 32'h14);
    step(2, 1'b0, 32'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
